mem_access_stage: RTL and testbench

- MEM stage of the 5-stage RV32 pipeline. Sits directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM outputs and performs the data-memory load/store over a ready/ack handshake.
- Stalls upstream while memory is busy and drives the MEM/WB pipeline register feeding writeback.
- Propagates the SQED valid bit under the separate outside_reset.

---
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32 pipeline: data-memory load/store over a req/ack handshake,
// upstream stall while memory is busy, and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        outside_reset,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] reg_data2_in,
  input  logic [4:0]  rd_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memtoReg_in,
  input  logic        regWrite_in,
  input  logic        qed_vld_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_res_out,
  output logic [4:0]  rd_out,
  output logic        memtoReg_out,
  output logic        regWrite_out,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        qed_vld_out_mem_wb
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_op, aligned;
  logic             capture, bubble, kill_wb, take_rdata, set_mis, set_bus;

  assign mem_op     = memRead_in | memWrite_in;
  assign aligned    = (alu_res_in[1:0] == 2'b00);
  assign dmem_we    = memWrite_in;
  assign dmem_addr  = {alu_res_in[31:2], 2'b00};
  assign dmem_wdata = reg_data2_in;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dmem_req   = 1'b0;
    stall_out  = 1'b0;
    capture    = 1'b0;
    bubble     = 1'b0;
    kill_wb    = 1'b0;
    take_rdata = 1'b0;
    set_mis    = 1'b0;
    set_bus    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mem_op) begin
          capture = 1'b1;
        end else if (!aligned) begin
          capture = 1'b1;
          kill_wb = 1'b1;
          set_mis = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            capture    = 1'b1;
            take_rdata = memRead_in;
          end else begin
            stall_out = 1'b1;
            bubble    = 1'b1;
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          dmem_req   = 1'b1;
          capture    = 1'b1;
          take_rdata = memRead_in;
          state_nxt  = S_IDLE;
          cnt_nxt    = '0;
        end else if (cnt == MAX_CNT) begin
          // Timeout: request is withdrawn and the instruction retires without writeback.
          capture   = 1'b1;
          kill_wb   = 1'b1;
          set_bus   = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          dmem_req  = 1'b1;
          stall_out = 1'b1;
          bubble    = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A pipeline reset kills any in-flight request in the same cycle.
    if (reset) begin
      dmem_req  = 1'b0;
      stall_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_out <= '0;
      alu_res_out  <= '0;
      rd_out       <= '0;
      memtoReg_out <= 1'b0;
      regWrite_out <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (capture) begin
        alu_res_out  <= alu_res_in;
        rd_out       <= rd_in;
        memtoReg_out <= memtoReg_in;
        regWrite_out <= regWrite_in & ~kill_wb;
        if (take_rdata) mem_data_out <= dmem_rdata;
      end else if (bubble) begin
        rd_out       <= '0;
        memtoReg_out <= 1'b0;
        regWrite_out <= 1'b0;
      end
      misalign_err <= misalign_err | set_mis;
      bus_err      <= bus_err | set_bus;
    end
  end

  // The QED valid bit lives in its own reset domain; the pipeline reset only freezes it.
  always_ff @(posedge clk) begin
    if (outside_reset) begin
      qed_vld_out_mem_wb <= 1'b0;
    end else if (!reset) begin
      qed_vld_out_mem_wb <= capture & qed_vld_in;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus queues expected MEM/WB records,
// a negedge monitor compares them on every capturing or reset cycle.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset, outside_reset;
  logic [31:0] alu_res_in, reg_data2_in, dmem_rdata;
  logic [4:0]  rd_in;
  logic        memRead_in, memWrite_in, memtoReg_in, regWrite_in, qed_vld_in, dmem_ack;
  logic        dmem_req, dmem_we, stall_out;
  logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_res_out;
  logic [4:0]  rd_out;
  logic        memtoReg_out, regWrite_out, misalign_err, bus_err, qed_vld_out_mem_wb;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .outside_reset(outside_reset),
    .alu_res_in(alu_res_in), .reg_data2_in(reg_data2_in), .rd_in(rd_in),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memtoReg_in(memtoReg_in), .regWrite_in(regWrite_in), .qed_vld_in(qed_vld_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .mem_data_out(mem_data_out), .alu_res_out(alu_res_out), .rd_out(rd_out),
    .memtoReg_out(memtoReg_out), .regWrite_out(regWrite_out),
    .misalign_err(misalign_err), .bus_err(bus_err), .qed_vld_out_mem_wb(qed_vld_out_mem_wb)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic [31:0] md;
    logic        qed;
    logic        mis;
    logic        bus;
  } wb_t;

  wb_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic armed = 1'b0;
  logic f_cap = 1'b0, f_bub = 1'b0, f_rst = 1'b0;

  function automatic wb_t cur_wb();
    return {alu_res_out, rd_out, memtoReg_out, regWrite_out, mem_data_out,
            qed_vld_out_mem_wb, misalign_err, bus_err};
  endfunction

  // Monitor: compares what the edge just before this negedge produced.
  always @(negedge clk) begin
    wb_t a, e;
    if (f_rst || f_cap) begin
      checks++;
      a = cur_wb();
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_record: actual=%h required=<none queued>", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL wb_record: actual=%h required=%h", a, e);
        end
      end
    end else if (f_bub) begin
      checks++;
      if ({regWrite_out, memtoReg_out, rd_out, qed_vld_out_mem_wb} !== 8'h00) begin
        errors++;
        $display("FAIL wb_bubble: actual=%b required=00000000",
                 {regWrite_out, memtoReg_out, rd_out, qed_vld_out_mem_wb});
      end
    end
    f_rst = armed && reset;
    f_cap = armed && !reset && !stall_out;
    f_bub = armed && !reset && stall_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                     input logic mr, input logic mw, input logic m2r, input logic rw,
                     input logic qed, input logic ack, input logic [31:0] rdata);
    alu_res_in = alu; reg_data2_in = wd; rd_in = rd;
    memRead_in = mr; memWrite_in = mw; memtoReg_in = m2r; regWrite_in = rw;
    qed_vld_in = qed; dmem_ack = ack; dmem_rdata = rdata;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic push(input wb_t r);
    exp_q.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; outside_reset = 1'b1;
    drv(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    tick(); tick();
    armed = 1'b1;
    push(wb_t'{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    tick();
    reset = 1'b0; outside_reset = 1'b0;

    // Plain ALU op
    drv(32'h1234, 32'h0, 5'd5, 0, 0, 0, 1, 1, 0, 32'h0);
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", stall_out, 0);
    push(wb_t'{32'h1234, 5'd5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
    tick();

    // Load with same-cycle ack
    drv(32'h100, 32'h0, 5'd7, 1, 0, 1, 1, 1, 1, 32'hDEADBEEF);
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall", stall_out, 0);
    push(wb_t'{32'h100, 5'd7, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
    tick();

    // Store acked on the 4th request cycle
    drv(32'h204, 32'hA5A5A5A5, 5'd0, 0, 1, 0, 0, 1, 0, 32'h0);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h204);
    for (int i = 0; i < 3; i++) begin
      chk("st_req_wait", dmem_req, 1);
      chk("st_stall_wait", stall_out, 1);
      tick();
    end
    dmem_ack = 1'b1; #1;
    chk("st_req_ack", dmem_req, 1);
    chk("st_stall_ack", stall_out, 0);
    push(wb_t'{32'h204, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
    tick();

    // Misaligned load
    drv(32'h102, 32'h0, 5'd9, 1, 0, 1, 1, 1, 0, 32'h0);
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall_out, 0);
    push(wb_t'{32'h102, 5'd9, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0});
    tick();

    // ALU op afterwards: misalign_err stays sticky, qed bit follows input
    drv(32'h55, 32'h0, 5'd2, 0, 0, 0, 1, 0, 0, 32'h0);
    push(wb_t'{32'h55, 5'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0});
    tick();

    // Load never acked: 4 stall cycles then abort
    drv(32'h300, 32'h0, 5'd4, 1, 0, 1, 1, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_wait", dmem_req, 1);
      chk("to_stall_wait", stall_out, 1);
      tick();
    end
    chk("to_req_abort", dmem_req, 0);
    chk("to_stall_abort", stall_out, 0);
    push(wb_t'{32'h300, 5'd4, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1});
    tick();
    drv(32'h77, 32'h0, 5'd1, 0, 0, 0, 1, 1, 0, 32'h0);
    chk("post_abort_req", dmem_req, 0);
    chk("post_abort_stall", stall_out, 0);
    push(wb_t'{32'h77, 5'd1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1});
    tick();

    // Reset during WAIT; the ack in the reset cycle is ignored
    drv(32'h400, 32'h0, 5'd6, 1, 0, 1, 1, 1, 0, 32'h0);
    tick();
    chk("rw_stall_wait1", stall_out, 1);
    tick();
    reset = 1'b1;
    drv(32'h400, 32'h0, 5'd6, 1, 0, 1, 1, 1, 1, 32'h12345678);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall_out, 0);
    push(wb_t'{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    tick();
    reset = 1'b0;
    drv(32'h88, 32'h0, 5'd8, 0, 0, 0, 1, 1, 0, 32'h0);
    chk("post_rst_req", dmem_req, 0);
    chk("post_rst_stall", stall_out, 0);
    push(wb_t'{32'h88, 5'd8, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
    tick();

    // Pipeline reset alone keeps the qed bit; with outside_reset it clears
    reset = 1'b1;
    push(wb_t'{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    tick();
    outside_reset = 1'b1;
    push(wb_t'{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    tick();
    reset = 1'b0;
    drv(32'h99, 32'h0, 5'd3, 0, 0, 0, 1, 1, 0, 32'h0);
    push(wb_t'{32'h99, 5'd3, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0});
    tick();
    outside_reset = 1'b0;
    armed = 1'b0;
    @(negedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
